// File: rtl/axi4_pkg.sv
// axi4_pkg: shared response/burst codes and FSM state types for the AXI4 slave memory.
package axi4_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // An out-of-range address outranks an unsupported burst type.
    function automatic logic [1:0] burst_resp(input logic addr_err, input logic [1:0] burst);
        return addr_err ? RESP_DECERR :
               (burst == BURST_FIXED || burst == BURST_INCR) ? RESP_OKAY : RESP_SLVERR;
    endfunction
endpackage

// File: rtl/axi4_mem_array.sv
// axi4_mem_array: word array with one byte-masked write port and one registered read port.
module axi4_mem_array #(
    parameter int data_wid = 64,
    parameter int mem_aw   = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [mem_aw-1:0]     waddr,
    input  logic [data_wid/8-1:0] wstrb,
    input  logic [data_wid-1:0]   wdata,
    input  logic                  re,
    input  logic [mem_aw-1:0]     raddr,
    output logic [data_wid-1:0]   rdata
);
    logic [data_wid-1:0] mem [2**mem_aw];

    // rdata only moves on re, so a stalled beat keeps its value even if its word is rewritten.
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < data_wid/8; b++)
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 burst slave backed by an on-chip word array.
// Independent write (AW/W/B) and read (AR/R) FSMs share the array.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int data_wid = 64,
    parameter int id_wid   = 8,
    parameter int mem_aw   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [id_wid-1:0]     AWID,
    input  logic [31:0]           AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [data_wid-1:0]   WDATA,
    input  logic [data_wid/8-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [id_wid-1:0]     BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [id_wid-1:0]     ARID,
    input  logic [31:0]           ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [id_wid-1:0]     RID,
    output logic [data_wid-1:0]   RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);
    localparam int lsb = $clog2(data_wid/8);
    localparam int hi  = lsb + mem_aw;

    w_state_t            w_state;
    r_state_t            r_state;
    logic [mem_aw-1:0]   w_idx, r_idx, aw_idx, ar_idx, r_next;
    logic                w_fixed, r_fixed, r_zero, aw_err, ar_err;
    logic [1:0]          w_resp;
    logic [7:0]          w_len, r_len, r_cnt;
    logic [8:0]          w_cnt;
    logic                w_fire, ar_fire, r_fire, mem_we, mem_re;
    logic [data_wid-1:0] mem_q;

    assign aw_err  = (AWADDR >> hi) != 32'd0;
    assign ar_err  = (ARADDR >> hi) != 32'd0;
    assign aw_idx  = mem_aw'(AWADDR >> lsb);
    assign ar_idx  = mem_aw'(ARADDR >> lsb);
    assign w_fire  = w_state == W_DATA && WVALID && WREADY;
    assign ar_fire = r_state == R_IDLE && ARVALID && ARREADY;
    assign r_fire  = r_state == R_DATA && RVALID && RREADY;
    assign r_next  = r_fixed ? r_idx : r_idx + 1'b1;
    assign mem_we  = w_fire && w_resp == RESP_OKAY;
    assign mem_re  = ar_fire || (r_fire && !RLAST);
    assign RDATA   = r_zero ? '0 : mem_q;

    axi4_mem_array #(.data_wid(data_wid), .mem_aw(mem_aw)) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(w_idx),
        .wstrb(WSTRB),
        .wdata(WDATA),
        .re   (mem_re),
        .raddr(ar_fire ? ar_idx : r_next),
        .rdata(mem_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        BID     <= AWID;
                        w_idx   <= aw_idx;
                        w_fixed <= AWBURST == BURST_FIXED;
                        w_resp  <= burst_resp(aw_err, AWBURST);
                        w_len   <= AWLEN;
                        w_cnt   <= '0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_fixed ? w_idx : w_idx + 1'b1;
                        w_cnt <= w_cnt[8] ? w_cnt : w_cnt + 1'b1;
                        if (WLAST) begin
                            // w_cnt still counts only the beats before this one.
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= w_resp != RESP_OKAY ? w_resp :
                                       w_cnt == {1'b0, w_len} ? RESP_OKAY : RESP_SLVERR;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RRESP   <= RESP_OKAY;
            r_zero  <= 1'b1;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        RID     <= ARID;
                        RRESP   <= burst_resp(ar_err, ARBURST);
                        r_zero  <= ar_err;
                        r_idx   <= ar_idx;
                        r_fixed <= ARBURST == BURST_FIXED;
                        r_len   <= ARLEN;
                        r_cnt   <= '0;
                        RLAST   <= ARLEN == 8'd0;
                        RVALID  <= 1'b1;
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_idx <= r_next;
                            r_cnt <= r_cnt + 8'd1;
                            RLAST <= r_cnt + 8'd1 == r_len;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb_axi4_slave_mem: directed checks of bursts, strobes, error responses, stalls and reset.
module tb_axi4_slave_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] rdat [16];
    logic [15:0] lastv;
    logic [1:0]  resp;
    logic [7:0]  id;

    always #5 clk = ~clk;

    axi4_slave_mem dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called on a negedge; beat i carries base+i and WLAST goes with beat `beats`-1.
    task automatic wr(input logic [7:0] wid, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [7:0] strb, input logic [63:0] base,
                      input int beats, output logic [1:0] bresp_o, output logic [7:0] bid_o);
        AWID = wid; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        chk("wready_latency", WREADY, 1);
        for (int i = 0; i < beats; i++) begin
            WVALID = 1'b1; WDATA = base + 64'(i); WSTRB = strb; WLAST = (i == beats - 1);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("bvalid_latency", BVALID, 1);
        bresp_o = BRESP; bid_o = BID;
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic rd(input logic [7:0] rid_i, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, output logic [1:0] rresp_o, output logic [7:0] rid_o);
        ARID = rid_i; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
        chk("rvalid_latency", RVALID, 1);
        RREADY = 1'b1;
        lastv = '0;
        rresp_o = RRESP; rid_o = RID;
        for (int i = 0; i <= int'(len); i++) begin
            rdat[i] = RDATA;
            lastv[i] = RLAST;
            @(negedge clk);
        end
        RREADY = 1'b0;
        chk("read_done", RVALID, 0);
    endtask

    initial begin
        rst = 1'b1;
        {AWID, AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
        {ARID, ARADDR, ARLEN, ARBURST, ARVALID, RREADY} = '0;
        repeat (2) @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_bresp_bid", {BRESP, BID}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_arready", ARREADY, 1);

        wr(8'h5A, 32'h10, 8'd3, 2'b01, 8'hFF, 64'd1, 4, resp, id);
        chk("incr_bresp", resp, 2'b00);
        chk("incr_bid", id, 8'h5A);
        rd(8'hA5, 32'h10, 8'd3, 2'b01, resp, id);
        for (int i = 0; i < 4; i++) chk("incr_rdata", rdat[i], 64'(i + 1));
        chk("incr_rlast", lastv[3:0], 4'b1000);
        chk("incr_rresp", resp, 2'b00);
        chk("incr_rid", id, 8'hA5);

        wr(8'h01, 32'h50, 8'd0, 2'b01, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, resp, id);
        wr(8'h01, 32'h50, 8'd0, 2'b01, 8'h0F, 64'h0, 1, resp, id);
        rd(8'h02, 32'h50, 8'd0, 2'b01, resp, id);
        chk("wstrb_merge", rdat[0], 64'hFFFF_FFFF_0000_0000);

        wr(8'h03, 32'h0, 8'd0, 2'b01, 8'hFF, 64'h1234, 1, resp, id);
        wr(8'h03, 32'h1_0000, 8'd0, 2'b01, 8'hFF, 64'hDEAD, 1, resp, id);
        chk("decerr_bresp", resp, 2'b11);
        rd(8'h04, 32'h0, 8'd0, 2'b01, resp, id);
        chk("decerr_mem_unchanged", rdat[0], 64'h1234);
        rd(8'h04, 32'h1_0000, 8'd0, 2'b01, resp, id);
        chk("decerr_rdata", rdat[0], 64'h0);
        chk("decerr_rresp", resp, 2'b11);

        wr(8'h05, 32'h100, 8'd3, 2'b01, 8'hFF, 64'h50, 2, resp, id);
        chk("short_burst_bresp", resp, 2'b10);
        chk("short_burst_bid", id, 8'h05);

        wr(8'h06, 32'h200, 8'd0, 2'b01, 8'hFF, 64'h11, 1, resp, id);
        wr(8'h06, 32'h200, 8'd1, 2'b10, 8'hFF, 64'h77, 2, resp, id);
        chk("bad_burst_bresp", resp, 2'b10);
        rd(8'h06, 32'h200, 8'd1, 2'b11, resp, id);
        chk("bad_burst_rresp", resp, 2'b10);
        rd(8'h06, 32'h200, 8'd0, 2'b00, resp, id);
        chk("bad_burst_no_write", rdat[0], 64'h11);

        wr(8'h07, 32'h180, 8'd1, 2'b00, 8'hFF, 64'h7, 2, resp, id);
        chk("fixed_bresp", resp, 2'b00);
        rd(8'h07, 32'h180, 8'd0, 2'b01, resp, id);
        chk("fixed_last_wins", rdat[0], 64'h8);

        wr(8'h08, 32'h140, 8'd3, 2'b01, 8'hFF, 64'h100, 4, resp, id);
        ARID = 8'h09; ARADDR = 32'h140; ARLEN = 8'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
        chk("stall_beat0", RDATA, 64'h100);
        RREADY = 1'b1;
        @(negedge clk);
        RREADY = 1'b0;
        AWID = 8'h08; AWADDR = 32'h148; AWLEN = 8'd0; AWBURST = 2'b01; AWVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_rdata_held", RDATA, 64'h101);
            chk("stall_rvalid_held", {RVALID, RLAST}, 2'b10);
            if (c == 0) begin
                AWVALID = 1'b0; WVALID = 1'b1; WDATA = 64'hBEEF; WSTRB = 8'hFF; WLAST = 1'b1;
            end else if (c == 1) begin
                WVALID = 1'b0; WLAST = 1'b0;
                chk("stall_write_bvalid", {BVALID, BRESP}, 3'b100);
                BREADY = 1'b1;
            end else begin
                BREADY = 1'b0;
            end
        end
        RREADY = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("stall_resume_rdata", RDATA, 64'h100 + 64'(i));
            chk("stall_resume_rlast", RLAST, (i == 3));
            @(negedge clk);
        end
        RREADY = 1'b0;
        chk("stall_burst_done", RVALID, 0);
        rd(8'h09, 32'h148, 8'd0, 2'b01, resp, id);
        chk("stall_write_landed", rdat[0], 64'hBEEF);

        AWID = 8'h0A; AWADDR = 32'h60; AWLEN = 8'd3; AWBURST = 2'b01; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        chk("rst_mid_wready_pre", WREADY, 1);
        WVALID = 1'b1; WDATA = 64'h5; WSTRB = 8'hFF; WLAST = 1'b0;
        @(negedge clk);
        WVALID = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wready", WREADY, 0);
        chk("rst_mid_awready", AWREADY, 0);
        chk("rst_mid_bvalid", BVALID, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_awready_after", AWREADY, 1);
        chk("rst_mid_no_bvalid", {BVALID, WREADY}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter data_wid, default 64, the W/R data width in bits; WSTRB width is data_wid/8.
REQ-002 SHALL have parameter id_wid, default 8, the AWID/ARID/BID/RID width.
REQ-003 SHALL have parameter mem_aw, default 8, the word-index width; the array holds 2**mem_aw words.
REQ-004 clk  in  1  single clock; one clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 AWID  in  id_wid  write burst ID.
REQ-007 AWADDR  in  32  write byte address.
REQ-008 AWLEN  in  8  write beats minus 1.
REQ-009 AWBURST  in  2  burst type; 00 FIXED, 01 INCR.
REQ-010 AWVALID / AWREADY  in / out  1 each  AW handshake pair.
REQ-011 WDATA  in  data_wid  write data.
REQ-012 WSTRB  in  data_wid/8  byte enables.
REQ-013 WLAST  in  1  last write beat.
REQ-014 WVALID / WREADY  in / out  1 each  W handshake pair.
REQ-015 BID  out  id_wid  captured AWID.
REQ-016 BRESP  out  2  write response.
REQ-017 BVALID / BREADY  out / in  1 each  B handshake pair.
REQ-018 ARID  in  id_wid  read burst ID.
REQ-019 ARADDR  in  32  read byte address.
REQ-020 ARLEN  in  8  read beats minus 1.
REQ-021 ARBURST  in  2  burst type; 00 FIXED, 01 INCR.
REQ-022 ARVALID / ARREADY  in / out  1 each  AR handshake pair.
REQ-023 RID  out  id_wid  captured ARID.
REQ-024 RDATA  out  data_wid  read data.
REQ-025 RRESP  out  2  read response.
REQ-026 RLAST / RVALID / RREADY  out / out / in  1 each  last read beat and R handshake pair.

Function
REQ-027 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP.
- W_IDLE: AWREADY=1; AW handshake captures ID/addr/len/burst and moves to W_DATA.
- W_DATA: WREADY=1; each handshake writes WSTRB-enabled bytes; WLAST moves to W_RESP.
- W_RESP: BVALID=1 held until BREADY; then returns to W_IDLE.
REQ-028 Read FSM states SHALL be R_IDLE, R_DATA.
- R_IDLE: ARREADY=1; AR handshake moves to R_DATA.
- R_DATA: RVALID=1; RLAST=1 on beat ARLEN; handshake with RLAST returns to R_IDLE.
REQ-029 Latency SHALL be as follows:
- AW handshake in cycle N gives WREADY in N+1.
- Final W handshake in cycle M gives BVALID in M+1.
- AR handshake in cycle N gives first RVALID/RDATA in N+1.
- Subsequent beats are back-to-back while RREADY=1.
REQ-030 RDATA/RID/RRESP/RLAST SHALL be registered and stay stable while RVALID=1 and RREADY=0.
REQ-031 Word index SHALL be addr[log2(data_wid/8)+mem_aw-1 : log2(data_wid/8)].
- INCR: index increments per beat, wrapping modulo 2**mem_aw.
- FIXED: index is constant.
REQ-032 An address with any bit set above the index field SHALL give response DECERR (11) for the whole burst; writes are dropped and RDATA reads as 0.
REQ-033 AWBURST/ARBURST of 10 or 11 SHALL give SLVERR (10); all beats are still accepted or returned, and no memory writes occur.
REQ-034 If WLAST arrives on a beat count other than AWLEN+1, BRESP SHALL be SLVERR; the burst still terminates on WLAST.
- Beat count saturates at 256.
REQ-035 Otherwise responses SHALL be OKAY (00), with BID=captured AWID and RID=captured ARID.
REQ-036 Read and write channels SHALL operate concurrently.
- A same-cycle write and read to the same word returns old data.
- A write landing on the word of a stalled R beat does not alter the held RDATA.

Reset
REQ-037 While rst=1 at a clock edge, the block SHALL:
- set AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST to 0;
- set BID, BRESP, RID, RRESP and RDATA to 0;
- force both FSMs to idle, abandoning any in-flight burst.
The memory array is not cleared. AWREADY/ARREADY assert in the first cycle after rst deasserts.

Structure
REQ-038 Package axi4_pkg SHALL hold the response codes (OKAY/SLVERR/DECERR), the burst codes (FIXED/INCR) and both FSM state enums.
REQ-039 The storage SHALL be sub-module axi4_mem_array, with one byte-masked write port and one synchronous read port.

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
- INCR write AWADDR=0x10, AWLEN=3, data 1..4, WSTRB=FF, then read the same burst -> RDATA 1,2,3,4; RLAST on the 4th beat; BRESP=RRESP=00; BID/RID echo the requested IDs.
- WSTRB=0x0F over a word holding 0xFFFF_FFFF_FFFF_FFFF with WDATA=0 -> read returns 0xFFFF_FFFF_0000_0000.
- AWADDR=0x1_0000 with mem_aw=8 -> BRESP=11 and memory unchanged; a read there -> RDATA=0, RRESP=11.
- AWLEN=3 with WLAST on beat 2 -> BRESP=10; BVALID one cycle after that beat.
- RREADY held low 5 cycles mid-burst while the same word is written -> RDATA unchanged, no beat lost.
- rst pulsed during W_DATA -> WREADY=0 next cycle; AWREADY=1 in the cycle after rst deasserts; no BVALID.
